data_sram_responder: RTL and testbench

- Responder end of the CPU data SRAM interface (en / we[3:0] / addr / wdata → rdata).
- Serves a synchronous word-addressed RAM plus a small memory-mapped config register region (scratch, LED, timer, number, switch).
- Fixed one-cycle read latency, which is what the pipeline's MEM stage expects.
- Instantiated beside the CPU top in the SoC/testbench; no ready or stall signal exists.

---
 rtl/data_sram_responder.sv | 126 ++++++++++++
 tb/tb_data_sram_responder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - CPU data SRAM responder: word RAM plus config registers, one-cycle read latency.
// Optional TIMER register/counter enabled by defining DATA_SRAM_RESPONDER_TIMER_EN.
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam logic [15:0] OFF_SCRATCH = 16'h0000;
  localparam logic [15:0] OFF_LED     = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_NUM     = 16'h000C;
  localparam logic [15:0] OFF_SWITCH  = 16'h0010;

  logic              conf_hit;
  logic              wr;
  logic              conf_wr;
  logic              ram_wr;
  logic [15:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       conf_rd;
  logic [31:0]       timer_rd;
  logic [31:0]       scratch_q;
  logic [15:0]       led_q;
  logic [31:0]       num_q;
  logic              unused_addr_lsb;

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign conf_hit        = ((data_sram_addr & CONF_MASK) == CONF_BASE);
  assign off             = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign wr              = data_sram_en & ~reset & (|data_sram_we);
  assign conf_wr         = wr & conf_hit;
  assign ram_wr          = wr & ~conf_hit;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // RAM is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++)
        if (data_sram_we[b]) mem[ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  always_comb begin
    conf_rd = '0;
    case (off)
      OFF_SCRATCH: conf_rd = scratch_q;
      OFF_LED:     conf_rd = {16'h0000, led_q};
      OFF_TIMER:   conf_rd = timer_rd;
      OFF_NUM:     conf_rd = num_q;
      OFF_SWITCH:  conf_rd = {16'h0000, switch_in};
      default:     conf_rd = '0;
    endcase
  end

  // Non-blocking sampling of the pre-edge values gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset)
      data_sram_rdata <= '0;
    else if (data_sram_en)
      data_sram_rdata <= conf_hit ? conf_rd : mem[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
      led_q     <= '0;
      num_q     <= '0;
    end else if (conf_wr) begin
      case (off)
        OFF_SCRATCH: scratch_q <= merge(scratch_q, data_sram_wdata, data_sram_we);
        OFF_LED: begin
          if (data_sram_we[0]) led_q[7:0]  <= data_sram_wdata[7:0];
          if (data_sram_we[1]) led_q[15:8] <= data_sram_wdata[15:8];
        end
        OFF_NUM:     num_q <= merge(num_q, data_sram_wdata, data_sram_we);
        default: ;
      endcase
    end
  end

`ifdef DATA_SRAM_RESPONDER_TIMER_EN
  logic [31:0] timer_q;

  // A write replaces this cycle's increment.
  always_ff @(posedge clk) begin
    if (reset)
      timer_q <= '0;
    else if (conf_wr && off == OFF_TIMER)
      timer_q <= merge(timer_q, data_sram_wdata, data_sram_we);
    else
      timer_q <= timer_q + 32'd1;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  assign led_out = led_q;
  assign num_out = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  int total = 0;
  int bad   = 0;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 4'hF, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'hF, 32'h0, 32'hFFFF_FFFF);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; switch_in = 16'h0;
    en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    idle(); idle();
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_num", num_out, 32'h0);
    reset = 1'b0;

    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010);
    check("ram_wr_rd", rdata, 32'h1234_5678);

    cyc(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
    rd(32'h0000_0010);
    check("byte_en", rdata, 32'h12BB_56DD);

    wr(32'h0001_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010);
    check("alias", rdata, 32'hDEAD_BEEF);

    wr(32'h0000_0010, 32'hCAFE_F00D);
    check("read_first", rdata, 32'hDEAD_BEEF);
    rd(32'h0000_0010);
    check("after_rf", rdata, 32'hCAFE_F00D);
    idle();
    check("hold_en0", rdata, 32'hCAFE_F00D);
    rd(32'h0000_0010);
    check("idle_no_write", rdata, 32'hCAFE_F00D);

    wr(32'h0000_0030, 32'h0000_0030);
    wr(32'h0000_0034, 32'h0000_0034);
    rd(32'h0000_0030);
    check("b2b_0", rdata, 32'h0000_0030);
    rd(32'h0000_0034);
    check("b2b_1", rdata, 32'h0000_0034);

    wr(32'hBFAF_0004, 32'hFFFF_00A5);
    check("led_out", {16'h0, led_out}, 32'h0000_00A5);
    rd(32'hBFAF_0004);
    check("led_rd", rdata, 32'h0000_00A5);

    switch_in = 16'h1234;
    rd(32'hBFAF_0010);
    check("switch", rdata, 32'h0000_1234);

    wr(32'hBFAF_0020, 32'hFFFF_FFFF);
    rd(32'hBFAF_0020);
    check("unmapped", rdata, 32'h0);

    wr(32'hBFAF_0000, 32'h1122_3344);
    wr(32'hBFAF_0000, 32'h5566_7788);
    check("scratch_rf", rdata, 32'h1122_3344);
    rd(32'hBFAF_0000);
    check("scratch", rdata, 32'h5566_7788);

    wr(32'hBFAF_0008, 32'h0000_0100);
    idle(); idle(); idle(); idle(); idle();
    rd(32'hBFAF_0008);
`ifdef DATA_SRAM_RESPONDER_TIMER_EN
    check("timer_run", rdata, 32'h0000_0105);
    rd(32'hBFAF_0008);
    check("timer_inc", rdata, 32'h0000_0106);
    wr(32'hBFAF_0008, 32'hFFFF_FFFF);
    idle();
    rd(32'hBFAF_0008);
    check("timer_wrap", rdata, 32'h0000_0000);
    rd(32'hBFAF_0008);
    check("timer_wrap1", rdata, 32'h0000_0001);
`else
    check("timer_off", rdata, 32'h0);
`endif

    wr(32'hBFAF_000C, 32'h5A5A_5A5A);
    check("num_out", num_out, 32'h5A5A_5A5A);
    wr(32'h0000_0020, 32'h0BAD_F00D);
    rd(32'hBFAF_000C);
    check("num_rd", rdata, 32'h5A5A_5A5A);

    reset = 1'b1;
    wr(32'h0000_0020, 32'hFFFF_FFFF);
    reset = 1'b0;
    check("rst_num", num_out, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    rd(32'h0000_0020);
    check("ram_kept", rdata, 32'h0BAD_F00D);
    rd(32'hBFAF_0000);
    check("rst_scratch", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
